// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a bounded hold time. The winner is kept as a
// registered index plus valid flag and expanded to a one-hot grant by decoder2x4.

module decoder2x4 (
  input  logic [1:0] in,
  input  logic       en,
  output logic [3:0] dout
);

  always_comb begin
    dout = 4'b0000;
    if (en) begin
      dout = 4'b0001 << in;
    end
  end

endmodule

module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {StIdle, StGrant} state_t;

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [1:0]       win_idx;
  logic [1:0]       cand;

  // Scan from the lowest priority upward so the last hit is the first in rotation.
  always_comb begin
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
      gnt_idx    <= 2'd0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|req) begin
            gnt_idx    <= win_idx;
            gnt_valid  <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= StGrant;
          end
        end
        StGrant: begin
          if (!req[gnt_idx] || (hold_cnt_q == HoldLast)) begin
            gnt_valid  <= 1'b0;
            ptr_q      <= gnt_idx + 2'd1;
            hold_cnt_q <= '0;
            state_q    <= StIdle;
            // Release takes precedence over expiry: no pulse if the request dropped.
            timeout    <= req[gnt_idx];
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  decoder2x4 u_dec (
    .in   (gnt_idx),
    .en   (gnt_valid),
    .dout (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: reset, single request, saturation, release/expiry
// tie, pointer wrap and asynchronous reset in the middle of a grant.

module tb_rr_arbiter4;

  logic       clk;
  logic       nrst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks;
  int failures;

  rr_arbiter4 #(
    .MAX_HOLD (8),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    req  = 4'b1111;
    #12;
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL reset_gnt got=%b want=0000", gnt);
    end
    checks++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_flags got valid=%b timeout=%b idx=%0d want 0/0/0",
               gnt_valid, timeout, gnt_idx);
    end
    nrst = 1'b1;
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got=%b want=0001", gnt);
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release got=%b want=0000", gnt);
    end
    step();
  endtask

  // ptr=1 on entry
  task automatic test_single();
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_valid !== 1'b1) begin
        failures++;
        $display("FAIL single_hold cyc=%0d got gnt=%b idx=%0d valid=%b want 0100/2/1",
                 c, gnt, gnt_idx, gnt_valid);
      end
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd2) begin
      failures++;
      $display("FAIL single_release got gnt=%b idx=%0d want 0000/2", gnt, gnt_idx);
    end
    req = 4'b1001;
    step();
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL single_ptr3 got=%b want=1000", gnt);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  // ptr=0 on entry
  task automatic test_saturate();
    logic [3:0] want;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      want = 4'b0001 << (g % 4);
      for (int c = 0; c < 8; c++) begin
        step();
        checks++;
        if (gnt !== want || timeout !== 1'b0) begin
          failures++;
          $display("FAIL sat_grant g=%0d cyc=%0d got gnt=%b to=%b want %b/0",
                   g, c, gnt, timeout, want);
        end
      end
      step();
      checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b1) begin
        failures++;
        $display("FAIL sat_expiry g=%0d got gnt=%b to=%b want 0000/1", g, gnt, timeout);
      end
    end
    req = 4'b0000;
    step();
    checks++;
    if (timeout !== 1'b0 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL sat_pulse_end got gnt=%b to=%b want 0000/0", gnt, timeout);
    end
  endtask

  // ptr=1 on entry
  task automatic test_tie();
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (gnt !== 4'b0001) begin
        failures++;
        $display("FAIL tie_hold cyc=%0d got=%b want=0001", c, gnt);
      end
    end
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL tie_release got gnt=%b to=%b want 0000/0", gnt, timeout);
    end
    req = 4'b1111;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL tie_ptr1 got=%b want=0010", gnt);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  // ptr=2 on entry
  task automatic test_wrap();
    req = 4'b1000;
    step();
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_grant3 got=%b want=1000", gnt);
    end
    req = 4'b0000;
    step();
    req = 4'b1010;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_ptr0 got=%b want=0010", gnt);
    end
    req = 4'b0000;
    step();
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL wrap_grant2 got=%b want=0100", gnt);
    end
    req = 4'b0000;
    step();
    req = 4'b0011;
    step();
    checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
      failures++;
      $display("FAIL wrap_ptr3 got gnt=%b idx=%0d want 0001/0", gnt, gnt_idx);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  // ptr=1 on entry
  task automatic test_async_reset();
    req = 4'b0100;
    step();
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL areset_pre got=%b want=0100", gnt);
    end
    #2;
    nrst = 1'b0;
    req  = 4'b0000;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0) begin
      failures++;
      $display("FAIL areset_drop got gnt=%b valid=%b idx=%0d want 0000/0/0",
               gnt, gnt_valid, gnt_idx);
    end
    #2;
    nrst = 1'b1;
    req  = 4'b0110;
    step();
    checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      failures++;
      $display("FAIL areset_after got gnt=%b idx=%0d want 0010/1", gnt, gnt_idx);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nrst     = 1'b0;
    req      = 4'b0000;
    test_reset();
    test_single();
    test_saturate();
    test_tie();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
